// File: rtl/rf_mp_sb.sv
// rf_mp_sb: multi-port GPR file with write-back scoreboard.
// NUM_RD combinational read ports, two write ports (port 1 is younger and wins
// on an address collision), one busy bit per register and a registered busy count.
// Optional write trace is compiled only when RF_TRACE_EN is defined.
module rf_mp_sb #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic [31:0]              wr0_pc,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [31:0]              wr1_pc,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // Next-state of the register array: port 1 applied last so it overrides port 0
    always_comb begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wr0_en && wr0_addr != '0) begin
            regs_d[wr0_addr] = wr0_data;
        end
        if (wr1_en && wr1_addr != '0) begin
            regs_d[wr1_addr] = wr1_data;
        end
    end

    // Scoreboard next-state (set beats clear) and its population count
    always_comb begin
        logic set_hit;
        logic clr_hit;
        set_hit = 1'b0;
        clr_hit = 1'b0;
        busy_d  = busy_q;
        cnt_d   = '0;
        for (int unsigned r = 1; r < DEPTH; r++) begin
            set_hit = sb_set_en && (sb_set_addr == ADDR_W'(r));
            clr_hit = (wr0_en && (wr0_addr == ADDR_W'(r))) ||
                      (wr1_en && (wr1_addr == ADDR_W'(r)));
            if (set_hit) begin
                busy_d[r] = 1'b1;
            end else if (clr_hit) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
        // The count tracks the next busy vector, which equals +1/-1 per real transition
        for (int unsigned r = 0; r < DEPTH; r++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[r]);
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        logic              hit0;
        logic              hit1;
        logic              set_hit;
        a       = '0;
        d       = '0;
        b       = 1'b0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        set_hit = 1'b0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            a       = rd_addr[k*ADDR_W +: ADDR_W];
            d       = regs_q[a];
            b       = busy_q[a];
            hit0    = wr0_en && (wr0_addr == a);
            hit1    = wr1_en && (wr1_addr == a);
            set_hit = sb_set_en && (sb_set_addr == a);
            if (BYPASS != 0) begin
                if (hit1) begin
                    d = wr1_data;
                end else if (hit0) begin
                    d = wr0_data;
                end
                if ((hit0 || hit1) && !set_hit) begin
                    b = 1'b0;
                end
            end
            // Outputs are forced quiet while reset is held, even if bypass data is present
            if (!reset || a == '0) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[k*DATA_W +: DATA_W] = d;
            rd_busy[k]                  = b;
        end
    end

`ifdef RF_TRACE_EN
    // Write trace, port 0 first; writes to register 0 show zero data
    always_ff @(posedge clk) begin
        if (reset) begin
            if (wr0_en) begin
                $display("%d@%h: $%d <= %h", $time, wr0_pc, wr0_addr,
                         (wr0_addr == '0) ? {DATA_W{1'b0}} : wr0_data);
            end
            if (wr1_en) begin
                $display("%d@%h: $%d <= %h", $time, wr1_pc, wr1_addr,
                         (wr1_addr == '0) ? {DATA_W{1'b0}} : wr1_data);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{wr0_pc, wr1_pc};
`endif

endmodule

// File: tb/tb_rf_mp_sb.sv
// Bench for rf_mp_sb: one forwarding and one non-forwarding instance share stimulus.
module tb_rf_mp_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rd_addr;
    logic [63:0] byp_rd_data, nob_rd_data;
    logic [1:0]  byp_rd_busy, nob_rd_busy;
    logic        wr0_en, wr1_en, sb_set_en;
    logic [4:0]  wr0_addr, wr1_addr, sb_set_addr;
    logic [31:0] wr0_data, wr1_data, wr0_pc, wr1_pc;
    logic [5:0]  byp_cnt, nob_cnt;

    int errors = 0;
    int checks = 0;

    // reference state
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_cnt = 0;

    always #5 clk = ~clk;

    rf_mp_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(byp_rd_data), .rd_busy(byp_rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_pc(wr0_pc),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_pc(wr1_pc),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_cnt(byp_cnt)
    );

    rf_mp_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nob_rd_data), .rd_busy(nob_rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_pc(wr0_pc),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_pc(wr1_pc),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_cnt(nob_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input int k, input bit byp);
        logic [4:0] a;
        a = rd_addr[k*5 +: 5];
        if (!reset || a == 5'd0) return 32'd0;
        if (byp && wr1_en && wr1_addr == a) return wr1_data;
        if (byp && wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input int k, input bit byp);
        logic [4:0] a;
        bit written, setting;
        a = rd_addr[k*5 +: 5];
        written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
        setting = sb_set_en && sb_set_addr == a;
        if (!reset || a == 5'd0) return 32'd0;
        if (byp && written && !setting) return 32'd0;
        return {31'd0, m_busy[a]};
    endfunction

    // reference update: stored values, busy flags and a transition-counted busy total
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = 32'd0;
                m_busy[r] = 1'b0;
            end
            m_cnt = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                bit s, c, nb;
                s  = sb_set_en && sb_set_addr == 5'(r);
                c  = (wr0_en && wr0_addr == 5'(r)) || (wr1_en && wr1_addr == 5'(r));
                nb = s ? 1'b1 : (c ? 1'b0 : m_busy[r]);
                if (nb && !m_busy[r]) m_cnt = m_cnt + 1;
                if (!nb && m_busy[r]) m_cnt = m_cnt - 1;
                m_busy[r] = nb;
            end
            if (wr0_en && wr0_addr != 5'd0) m_mem[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 5'd0) m_mem[wr1_addr] = wr1_data;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("byp_rd_data", byp_rd_data[k*32 +: 32], exp_data(k, 1'b1));
            chk("nob_rd_data", nob_rd_data[k*32 +: 32], exp_data(k, 1'b0));
            chk("byp_rd_busy", {31'd0, byp_rd_busy[k]}, exp_busy(k, 1'b1));
            chk("nob_rd_busy", {31'd0, nob_rd_busy[k]}, exp_busy(k, 1'b0));
        end
        chk("byp_busy_cnt", {26'd0, byp_cnt}, 32'(m_cnt));
        chk("nob_busy_cnt", {26'd0, nob_cnt}, 32'(m_cnt));
    end

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        wr0_pc = 32'h0000_1000;
        wr1_pc = 32'h0000_1004;
        rd_addr = '0;
        idle();
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // r5, r3 written, r6 marked busy
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h1111_1111;
        sb_set_en = 1; sb_set_addr = 6;
        tick(); idle();
        rd_addr = {5'd3, 5'd5};
        #2;
        chk("lit_r5", byp_rd_data[31:0], 32'h1234);
        chk("lit_r3", nob_rd_data[63:32], 32'h1111_1111);
        chk("lit_cnt1", {26'd0, byp_cnt}, 32'd1);
        // reset mid-cycle clears without a clock edge
        reset = 1'b0;
        #1;
        chk("lit_rst_r5", byp_rd_data[31:0], 32'd0);
        chk("lit_rst_r5_nob", nob_rd_data[31:0], 32'd0);
        chk("lit_rst_cnt", {26'd0, byp_cnt}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // forwarding vs stored value
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h1111_1111;
        tick(); idle();
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'hAAAA_0000;
        rd_addr = {5'd0, 5'd3};
        #2;
        chk("lit_byp_fwd", byp_rd_data[31:0], 32'hAAAA_0000);
        chk("lit_nob_old", nob_rd_data[31:0], 32'h1111_1111);
        tick(); idle();
        #2;
        chk("lit_nob_new", nob_rd_data[31:0], 32'hAAAA_0000);

        // collision on r7: younger port wins
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'd1;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'd2;
        rd_addr = {5'd0, 5'd7};
        #2;
        chk("lit_coll_fwd", byp_rd_data[31:0], 32'd2);
        tick(); idle();
        #2;
        chk("lit_coll_byp", byp_rd_data[31:0], 32'd2);
        chk("lit_coll_nob", nob_rd_data[31:0], 32'd2);

        // scoreboard set then clear by write port 1
        sb_set_en = 1; sb_set_addr = 9;
        tick(); idle();
        rd_addr = {5'd9, 5'd7};
        #2;
        chk("lit_r9_busy", {31'd0, byp_rd_busy[1]}, 32'd1);
        chk("lit_r9_cnt", {26'd0, byp_cnt}, 32'd1);
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'h55;
        #2;
        chk("lit_r9_byp_busy", {31'd0, byp_rd_busy[1]}, 32'd0);
        chk("lit_r9_nob_busy", {31'd0, nob_rd_busy[1]}, 32'd1);
        tick(); idle();
        #2;
        chk("lit_r9_clr_cnt", {26'd0, nob_cnt}, 32'd0);
        chk("lit_r9_clr_busy", {31'd0, byp_rd_busy[1]}, 32'd0);

        // set beats clear on a busy register
        sb_set_en = 1; sb_set_addr = 4;
        tick(); idle();
        rd_addr = {5'd0, 5'd4};
        sb_set_en = 1; sb_set_addr = 4;
        wr0_en = 1; wr0_addr = 4; wr0_data = 32'h44;
        #2;
        chk("lit_r4_busy_pre", {31'd0, byp_rd_busy[0]}, 32'd1);
        tick(); idle();
        #2;
        chk("lit_r4_busy", {31'd0, byp_rd_busy[0]}, 32'd1);
        chk("lit_r4_cnt", {26'd0, byp_cnt}, 32'd1);
        chk("lit_r4_data", byp_rd_data[31:0], 32'h44);
        wr1_en = 1; wr1_addr = 4; wr1_data = 32'h45;
        tick(); idle();

        // register 0 ignores writes and sets
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF;
        sb_set_en = 1; sb_set_addr = 0;
        rd_addr = {5'd0, 5'd0};
        #2;
        chk("lit_r0_fwd", byp_rd_data[31:0], 32'd0);
        chk("lit_r0_busy", {31'd0, byp_rd_busy[0]}, 32'd0);
        tick(); idle();
        #2;
        chk("lit_r0_cnt", {26'd0, byp_cnt}, 32'd0);
        chk("lit_r0_data", nob_rd_data[31:0], 32'd0);

        // fill the scoreboard to its maximum
        for (int i = 1; i < 32; i++) begin
            sb_set_en = 1; sb_set_addr = 5'(i);
            rd_addr = {5'(i), 5'(i - 1)};
            tick();
        end
        idle();
        #2;
        chk("lit_cnt_full", {26'd0, byp_cnt}, 32'd31);
        sb_set_en = 1; sb_set_addr = 31;
        tick(); idle();
        #2;
        chk("lit_cnt_reset_busy", {26'd0, byp_cnt}, 32'd31);

        // drain two per cycle while writing a pattern
        for (int i = 1; i < 32; i += 2) begin
            wr0_en = 1; wr0_addr = 5'(i);     wr0_data = 32'(i) * 32'h0101_0101;
            wr1_en = 1; wr1_addr = 5'(i + 1); wr1_data = 32'(i + 1) * 32'h0101_0101;
            rd_addr = {5'(i + 1), 5'(i)};
            tick();
        end
        idle();
        #2;
        chk("lit_cnt_empty", {26'd0, byp_cnt}, 32'd0);
        wr0_en = 1; wr0_addr = 10; wr0_data = 32'h0A0A_0A0A;
        tick(); idle();
        #2;
        chk("lit_cnt_idle_clr", {26'd0, nob_cnt}, 32'd0);

        // read sweep over all addresses
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            tick();
        end
        rd_addr = {5'd2, 5'd31};
        #2;
        chk("lit_r31", nob_rd_data[31:0], 32'h1F1F_1F1F);
        chk("lit_r2", byp_rd_data[63:32], 32'h0202_0202);

        // reset held across an edge drops the write and the set
        wr0_en = 1; wr0_addr = 12; wr0_data = 32'hDEAD_BEEF;
        sb_set_en = 1; sb_set_addr = 13;
        rd_addr = {5'd13, 5'd12};
        reset = 1'b0;
        tick(); idle();
        reset = 1'b1;
        #2;
        chk("lit_rst_wr", byp_rd_data[31:0], 32'd0);
        chk("lit_rst_set", {26'd0, byp_cnt}, 32'd0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
